huffman_packer: RTL and testbench

//  Downstream of the Huffman code generator. Captures the 6-entry code table (HCn/Mn) on code_valid.

---
 rtl/huffman_packer.sv | 152 +++++++++++++++
 tb/tb_huffman_packer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/huffman_packer.sv
// Huffman bit packer: loads a 6-entry code table, then packs symbol
// codewords MSB-first into a byte stream with valid/ready on both sides.
module huffman_packer #(
  parameter int TOT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [7:0]       HC1,
  input  logic [7:0]       HC2,
  input  logic [7:0]       HC3,
  input  logic [7:0]       HC4,
  input  logic [7:0]       HC5,
  input  logic [7:0]       HC6,
  input  logic [7:0]       M1,
  input  logic [7:0]       M2,
  input  logic [7:0]       M3,
  input  logic [7:0]       M4,
  input  logic [7:0]       M5,
  input  logic [7:0]       M6,
  input  logic             sym_valid,
  input  logic [7:0]       sym_data,
  output logic             sym_ready,
  input  logic             flush,
  output logic             byte_valid,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  input  logic             byte_ready,
  output logic             flush_done,
  output logic             sym_err,
  output logic [TOT_W-1:0] bit_total
);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t state, state_next;

  logic [7:0]  code_q [6];
  logic [3:0]  len_q  [6];
  logic [7:0]  hc_in  [6];
  logic [7:0]  m_in   [6];
  logic [15:0] shreg, shreg_next;
  logic [4:0]  count, cnt_next, base_cnt;
  logic [15:0] shifted, app;
  logic [4:0]  sh;
  logic [2:0]  idx;
  logic        sym_ok, push, pop, last_pop, done_fire;
  logic [7:0]  code_sel, code_add;
  logic [3:0]  len_sel, len_add;
  logic [TOT_W:0] tot_sum;

  function automatic logic [3:0] popcnt(input logic [7:0] m);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + {3'b000, m[i]};
    return n;
  endfunction

  assign sym_ready  = (state == RUN) && (count <= 5'd8);
  assign byte_valid = (count >= 5'd8) ||
                      ((state == FLUSH) && (count != 5'd0));
  assign byte_last  = (state == FLUSH) && (count != 5'd0) &&
                      (count <= 5'd8);
  assign byte_data  = shreg[15:8];

  always_comb begin
    hc_in = '{HC1, HC2, HC3, HC4, HC5, HC6};
    m_in  = '{M1, M2, M3, M4, M5, M6};
  end

  always_comb begin
    push     = sym_valid && sym_ready;
    pop      = byte_valid && byte_ready;
    last_pop = pop && byte_last;
    idx      = sym_data[2:0] - 3'd1;
    sym_ok   = 1'b0;
    code_sel = '0;
    len_sel  = '0;
    if (sym_data >= 8'd1 && sym_data <= 8'd6) begin
      sym_ok   = 1'b1;
      code_sel = code_q[idx];
      len_sel  = len_q[idx];
    end
    code_add = push ? code_sel : 8'h00;
    len_add  = push ? len_sel : 4'd0;
    // pop is applied first, then the new code lands behind what remains
    shifted  = pop ? {shreg[7:0], 8'h00} : shreg;
    base_cnt = pop ? ((count > 5'd8) ? count - 5'd8 : 5'd0) : count;
    sh       = 5'd16 - base_cnt - {1'b0, len_add};
    app      = {8'h00, code_add} << sh;
    shreg_next = shifted | app;
    cnt_next   = base_cnt + {1'b0, len_add};
    tot_sum    = {1'b0, bit_total} + {{(TOT_W-3){1'b0}}, len_add};
  end

  always_comb begin
    state_next = state;
    done_fire  = 1'b0;
    unique case (state)
      IDLE: if (code_valid) state_next = RUN;
      RUN: begin
        if (flush) begin
          if (cnt_next == 5'd0) done_fire  = 1'b1;
          else                  state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (last_pop) begin
          state_next = RUN;
          done_fire  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 6; i++) begin
        code_q[i] <= '0;
        len_q[i]  <= '0;
      end
      shreg      <= '0;
      count      <= '0;
      bit_total  <= '0;
      sym_err    <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      if (code_valid) begin
        for (int i = 0; i < 6; i++) begin
          code_q[i] <= hc_in[i] & m_in[i];
          len_q[i]  <= popcnt(m_in[i]);
        end
        bit_total <= '0;
      end else if (tot_sum[TOT_W]) begin
        bit_total <= '1;
      end else begin
        bit_total <= tot_sum[TOT_W-1:0];
      end
      shreg      <= shreg_next;
      count      <= cnt_next;
      sym_err    <= push && !sym_ok;
      flush_done <= done_fire;
    end
  end

endmodule

// File: tb/tb_huffman_packer.sv
// Directed bench for huffman_packer: per-cycle vector table plus
// hand sequences for eight-symbol fill, code reload and async reset.
module tb_huffman_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        code_valid;
  logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
  logic [7:0]  M1, M2, M3, M4, M5, M6;
  logic        sym_valid;
  logic [7:0]  sym_data;
  logic        sym_ready;
  logic        flush;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic        byte_ready;
  logic        flush_done;
  logic        sym_err;
  logic [15:0] bit_total;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  huffman_packer #(.TOT_W(16)) dut (
    .clk(clk), .reset(reset), .code_valid(code_valid),
    .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
    .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .flush(flush), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_last(byte_last), .byte_ready(byte_ready),
    .flush_done(flush_done), .sym_err(sym_err), .bit_total(bit_total)
  );

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       fl;
    logic       br;
    logic       sr;
    logic       bv;
    logic [7:0] bd;
    logic       bl;
    logic       fd;
    logic       se;
    logic [15:0] bt;
  } vec_t;

  vec_t vt [36];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic sr, input logic bv,
                          input logic [7:0] bd, input logic bl,
                          input logic fd, input logic se,
                          input logic [15:0] bt);
    chk({tag, ".sym_ready"}, {31'd0, sym_ready}, {31'd0, sr});
    chk({tag, ".byte_valid"}, {31'd0, byte_valid}, {31'd0, bv});
    chk({tag, ".byte_data"}, {24'd0, byte_data}, {24'd0, bd});
    chk({tag, ".byte_last"}, {31'd0, byte_last}, {31'd0, bl});
    chk({tag, ".flush_done"}, {31'd0, flush_done}, {31'd0, fd});
    chk({tag, ".sym_err"}, {31'd0, sym_err}, {31'd0, se});
    chk({tag, ".bit_total"}, {16'd0, bit_total}, {16'd0, bt});
  endtask

  function automatic vec_t mk(logic sv, logic [7:0] sd, logic fl,
                              logic br, logic sr, logic bv,
                              logic [7:0] bd, logic bl, logic fd,
                              logic se, logic [15:0] bt);
    vec_t v;
    v.sv = sv; v.sd = sd; v.fl = fl; v.br = br;
    v.sr = sr; v.bv = bv; v.bd = bd; v.bl = bl;
    v.fd = fd; v.se = se; v.bt = bt;
    return v;
  endfunction

  initial begin
    // symbols 1..4 with ready high: 1|00|10|110 -> 0x96, then empty flush
    vt[0]  = mk(1, 1, 0, 1,  1, 0, 8'h00, 0, 0, 0, 0);
    vt[1]  = mk(1, 2, 0, 1,  1, 0, 8'h80, 0, 0, 0, 1);
    vt[2]  = mk(1, 3, 0, 1,  1, 0, 8'h80, 0, 0, 0, 3);
    vt[3]  = mk(1, 4, 0, 1,  1, 0, 8'h90, 0, 0, 0, 5);
    vt[4]  = mk(0, 0, 0, 1,  1, 1, 8'h96, 0, 0, 0, 8);
    vt[5]  = mk(0, 0, 1, 1,  1, 0, 8'h00, 0, 0, 0, 8);
    vt[6]  = mk(0, 0, 0, 1,  1, 0, 8'h00, 0, 1, 0, 8);
    vt[7]  = mk(0, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 8);
    // same symbols with ready low: the flush makes 0x96 the last byte
    vt[8]  = mk(1, 1, 0, 0,  1, 0, 8'h00, 0, 0, 0, 8);
    vt[9]  = mk(1, 2, 0, 0,  1, 0, 8'h80, 0, 0, 0, 9);
    vt[10] = mk(1, 3, 0, 0,  1, 0, 8'h80, 0, 0, 0, 11);
    vt[11] = mk(1, 4, 0, 0,  1, 0, 8'h90, 0, 0, 0, 13);
    vt[12] = mk(0, 0, 1, 0,  1, 1, 8'h96, 0, 0, 0, 16);
    vt[13] = mk(0, 0, 0, 0,  0, 1, 8'h96, 1, 0, 0, 16);
    vt[14] = mk(0, 0, 0, 1,  0, 1, 8'h96, 1, 0, 0, 16);
    vt[15] = mk(0, 0, 0, 1,  1, 0, 8'h00, 0, 1, 0, 16);
    vt[16] = mk(0, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 16);
    // padded byte 110|1 -> 0xD0, flush coincides with symbol handshake
    vt[17] = mk(1, 4, 0, 1,  1, 0, 8'h00, 0, 0, 0, 16);
    vt[18] = mk(1, 1, 1, 1,  1, 0, 8'hC0, 0, 0, 0, 19);
    vt[19] = mk(0, 0, 0, 1,  0, 1, 8'hD0, 1, 0, 0, 20);
    vt[20] = mk(0, 0, 0, 1,  1, 0, 8'h00, 0, 1, 0, 20);
    // invalid symbols 0 and 9
    vt[21] = mk(1, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 20);
    vt[22] = mk(1, 9, 0, 1,  1, 0, 8'h00, 0, 0, 1, 20);
    vt[23] = mk(0, 0, 0, 1,  1, 0, 8'h00, 0, 0, 1, 20);
    vt[24] = mk(0, 0, 0, 1,  1, 0, 8'h00, 0, 0, 0, 20);
    // backpressure with 4-bit codes, then push+pop together
    vt[25] = mk(1, 5, 0, 0,  1, 0, 8'h00, 0, 0, 0, 20);
    vt[26] = mk(1, 6, 0, 0,  1, 0, 8'hE0, 0, 0, 0, 24);
    vt[27] = mk(1, 5, 0, 0,  1, 1, 8'hEF, 0, 0, 0, 28);
    vt[28] = mk(1, 6, 0, 0,  0, 1, 8'hEF, 0, 0, 0, 32);
    vt[29] = mk(1, 6, 0, 1,  0, 1, 8'hEF, 0, 0, 0, 32);
    vt[30] = mk(1, 6, 0, 1,  1, 0, 8'hE0, 0, 0, 0, 32);
    vt[31] = mk(1, 5, 0, 1,  1, 1, 8'hEF, 0, 0, 0, 36);
    vt[32] = mk(0, 0, 0, 1,  1, 0, 8'hE0, 0, 0, 0, 40);
    vt[33] = mk(0, 0, 1, 1,  1, 0, 8'hE0, 0, 0, 0, 40);
    vt[34] = mk(0, 0, 0, 1,  0, 1, 8'hE0, 1, 0, 0, 40);
    vt[35] = mk(0, 0, 0, 1,  1, 0, 8'h00, 0, 1, 0, 40);

    reset = 1'b0;
    code_valid = 1'b0;
    HC1 = 8'd1;  HC2 = 8'd0;  HC3 = 8'd2;
    HC4 = 8'd6;  HC5 = 8'd14; HC6 = 8'd15;
    M1 = 8'h01; M2 = 8'h03; M3 = 8'h03;
    M4 = 8'h07; M5 = 8'h0F; M6 = 8'h0F;
    sym_valid = 1'b0;
    sym_data = 8'd0;
    flush = 1'b0;
    byte_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 8'h00, 0, 0, 0, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;

    for (int i = 0; i < 36; i++) begin
      sym_valid  = vt[i].sv;
      sym_data   = vt[i].sd;
      flush      = vt[i].fl;
      byte_ready = vt[i].br;
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), vt[i].sr, vt[i].bv, vt[i].bd,
               vt[i].bl, vt[i].fd, vt[i].se, vt[i].bt);
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
    flush = 1'b0;

    // eight 1-bit symbols: sym_ready stays high, one 0xFF not last
    byte_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sym_valid = 1'b1;
      sym_data  = 8'd1;
      @(negedge clk);
      chk($sformatf("ones%0d.sym_ready", i), {31'd0, sym_ready}, 32'd1);
      @(posedge clk);
      #1;
    end
    sym_valid = 1'b0;
    @(negedge clk);
    chk("ones.byte_valid", {31'd0, byte_valid}, 32'd1);
    chk("ones.byte_data", {24'd0, byte_data}, 32'hFF);
    chk("ones.byte_last", {31'd0, byte_last}, 32'd0);
    chk("ones.bit_total", {16'd0, bit_total}, 32'd48);
    @(posedge clk);
    #1;
    chk("ones.drained", {31'd0, byte_valid}, 32'd0);

    // table reload clears bit_total
    code_valid = 1'b1;
    @(posedge clk);
    #1;
    code_valid = 1'b0;
    chk("reload.bit_total", {16'd0, bit_total}, 32'd0);

    // async reset while a byte is pending
    byte_ready = 1'b0;
    sym_valid = 1'b1;
    sym_data = 8'd5;
    @(posedge clk);
    #1;
    sym_data = 8'd6;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    chk("pre_rst.byte_valid", {31'd0, byte_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk_outs("async_rst", 0, 0, 8'h00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    sym_valid = 1'b1;
    sym_data = 8'd1;
    flush = 1'b1;
    @(negedge clk);
    chk("idle.sym_ready0", {31'd0, sym_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("idle.sym_ready1", {31'd0, sym_ready}, 32'd0);
    chk("idle.flush_done", {31'd0, flush_done}, 32'd0);
    chk("idle.byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("idle.bit_total", {16'd0, bit_total}, 32'd0);
    sym_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
